cube_scan_sequencer: RTL and testbench
======================================

# cube_scan_sequencer

Time-multiplexes the LED cube: steps through every layer and, within each layer, every binary-code-modulation (BCM) bit plane. Each slot is blanked, a column-data shift is requested from the shift-register loader, the data is latched, and the layer is displayed for a duration weighted by 2^bit_plane. It sits between the frame buffer/shift loader and the layer drivers, and replaces the free-running counter as the scan timebase.

## Interface
- `LAYERS`, 16: number of cube layers; must be ≥ 2.
- `BITS`, 8: BCM bit planes per layer; must be ≥ 1.
- `TICK_SHIFT`, 4: base display time is 2^TICK_SHIFT clk cycles for bit plane 0.
- `BLANK_CYCLES`, 2: cycles with `oe`=0 before each load; must be ≥ 1.
- `LW` = max(1, $clog2(LAYERS)) and `BW` = max(1, $clog2(BITS)) are derived widths.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; sampled in IDLE and at the end of SHOW.
- `load_ack`  in  1  loader has finished shifting the slot data; sampled only while `load_req`=1.
- `layer`  out  LW  current layer index.
- `bit_plane`  out  BW  current BCM bit plane.
- `load_req`  out  1  request to shift data for (`layer`, `bit_plane`).
- `latch`  out  1  one-cycle strobe that transfers shifted data to the output registers.
- `oe`  out  1  layer drive enable; 1 = LEDs lit.
- `frame_start`  out  1  one-cycle pulse at the first cycle of each frame.

## Operation
- All outputs are registered. After reset: state IDLE and all outputs 0 (`layer`=0, `bit_plane`=0).
- **IDLE**: `oe`=0. If `enable`=1, go to BLANK with `layer`=0, `bit_plane`=0.
- **BLANK**: `oe`=0 for exactly BLANK_CYCLES cycles, then go to LOAD.
- **LOAD**: `load_req`=1, held until `load_ack` is sampled high while `load_req`=1. `load_req` is 0 in the next cycle, and the state moves to LATCH. A `load_ack` seen outside LOAD is ignored. There is no timeout: LOAD waits indefinitely.
- **LATCH**: `latch`=1 for exactly one cycle, then go to SHOW.
- **SHOW**: `oe`=1 for exactly 2^(`bit_plane`+TICK_SHIFT) cycles. The display down-counter is BITS+TICK_SHIFT bits wide and is loaded on entry to SHOW.
- End of SHOW: if `enable`=0, go to IDLE and clear `layer` and `bit_plane` to 0. Otherwise advance and go to BLANK:
  - `bit_plane`+1, wrapping from BITS-1 to 0.
  - On a bit_plane wrap, `layer`+1, wrapping from LAYERS-1 to 0. The wrap is explicit and does not rely on power-of-two rollover.
- `frame_start`=1 in the first BLANK cycle of every slot with `layer`=0 and `bit_plane`=0, including the first slot after IDLE.
- `layer` and `bit_plane` change only on the cycle BLANK is entered, so they never change while `oe`=1 or `load_req`=1.
- `enable` deasserted mid-slot has no effect until SHOW completes. The current slot always finishes.
- `reset` overrides everything, including mid-LOAD and mid-SHOW. On the next edge all outputs are 0 and the state is IDLE.
- Invariants:
  - `oe`, `load_req` and `latch` are mutually exclusive.
  - `oe` is never 1 in the cycle adjacent to `latch`=1 other than the cycle that follows it (SHOW entry).

## Timing
- From `enable`=1 sampled in IDLE to the first BLANK cycle (`frame_start`=1): 1 cycle.
- Slot length = BLANK_CYCLES + L + 1 + 2^(b+TICK_SHIFT), where L ≥ 1 is the number of `load_req` cycles. L=1 when `load_ack` is high in the first LOAD cycle.
- Minimum frame length = LAYERS·BITS·(BLANK_CYCLES+2) + LAYERS·2^TICK_SHIFT·(2^BITS−1).
- `load_ack` is treated as synchronous to `clk`; it may be asserted combinationally in response to `load_req`.

## Test plan
- Reset/idle: hold `reset` for 3 cycles with `enable`=1. Then all outputs are 0. Release `reset` → `frame_start`=1 exactly 1 cycle later, with `layer`=0 and `bit_plane`=0.
- Nominal sequence (LAYERS=2, BITS=2, TICK_SHIFT=0, BLANK_CYCLES=2, `load_ack` tied 1):
  - Slots are 5, 6, 5, 6 cycles long.
  - `oe` is high for 1, 2, 1, 2 cycles.
  - (`layer`,`bit_plane`) steps (0,0) → (0,1) → (1,0) → (1,1).
  - `frame_start` period is 22 cycles.
- Ack stall: delay `load_ack` by 7 cycles → `load_req` stays high for 8 cycles. `latch` pulses once, 1 cycle after the ack is sampled. `oe` stays 0 throughout.
- Non-power-of-two wrap: LAYERS=3, BITS=3 → `layer` sequence 0,1,2,0 and `bit_plane` 0,1,2,0. Indices never reach 3.
- Enable drop: deassert `enable` in the middle of SHOW for (1,1).
  - SHOW completes its full length, then the state goes to IDLE with all outputs 0.
  - Re-enable → `frame_start` again, with `layer`=0.
- Reset mid-LOAD and mid-SHOW: assert `reset` for 1 cycle → the next cycle shows `oe`=`load_req`=`latch`=0 and indices 0. A late `load_ack` arriving afterwards is ignored.

Source files
------------

// File: rtl/cube_scan_sequencer_if.sv
// Handshake bundle between the cube scan sequencer, the shift loader and the layer drivers.
// The sequencer drives the scan position and strobes. The system side supplies run and ack.
interface cube_scan_sequencer_if #(
  parameter int LW = 4,
  parameter int BW = 3
);
  logic          enable;
  logic          load_ack;
  logic [LW-1:0] layer;
  logic [BW-1:0] bit_plane;
  logic          load_req;
  logic          latch;
  logic          oe;
  logic          frame_start;

  modport master (
    input  enable,
    input  load_ack,
    output layer,
    output bit_plane,
    output load_req,
    output latch,
    output oe,
    output frame_start
  );

  modport slave (
    output enable,
    output load_ack,
    input  layer,
    input  bit_plane,
    input  load_req,
    input  latch,
    input  oe,
    input  frame_start
  );
endinterface

// File: rtl/cube_scan_sequencer.sv
// LED cube scan timebase: walks every layer and BCM bit plane with blank/load/latch/show slots.
// Each slot's display time is weighted by 2^(bit_plane+TICK_SHIFT).
module cube_scan_sequencer #(
  parameter int LAYERS       = 16,
  parameter int BITS         = 8,
  parameter int TICK_SHIFT   = 4,
  parameter int BLANK_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  cube_scan_sequencer_if.master bus
);
  localparam int LW  = ($clog2(LAYERS) > 1) ? $clog2(LAYERS) : 1;
  localparam int BW  = ($clog2(BITS) > 1) ? $clog2(BITS) : 1;
  localparam int CW  = BITS + TICK_SHIFT;
  localparam int BCW = ($clog2(BLANK_CYCLES) > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    LOAD,
    LATCH,
    SHOW
  } state_t;

  state_t         state;
  logic [LW-1:0]  layer_q;
  logic [BW-1:0]  bit_q;
  logic           load_req_q;
  logic           latch_q;
  logic           oe_q;
  logic           frame_start_q;
  logic [BCW-1:0] blank_cnt;
  logic [CW-1:0]  show_cnt;

  logic           last_bit;
  logic           last_layer;
  logic [LW-1:0]  next_layer;
  logic [BW-1:0]  next_bit;
  logic           next_frame;
  logic [CW-1:0]  show_load;

  // Explicit index wrap so non-power-of-two cube sizes never reach out-of-range values.
  always_comb begin
    last_bit   = (bit_q == BW'(BITS - 1));
    last_layer = (layer_q == LW'(LAYERS - 1));
    next_bit   = last_bit ? '0 : bit_q + BW'(1);
    next_layer = layer_q;
    if (last_bit) begin
      next_layer = last_layer ? '0 : layer_q + LW'(1);
    end
    next_frame = last_bit && last_layer;
    show_load  = (CW'(1) << (32'(bit_q) + TICK_SHIFT)) - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      layer_q       <= '0;
      bit_q         <= '0;
      load_req_q    <= 1'b0;
      latch_q       <= 1'b0;
      oe_q          <= 1'b0;
      frame_start_q <= 1'b0;
      blank_cnt     <= '0;
      show_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state         <= BLANK;
            layer_q       <= '0;
            bit_q         <= '0;
            frame_start_q <= 1'b1;
            blank_cnt     <= BCW'(BLANK_CYCLES - 1);
          end
        end
        BLANK: begin
          frame_start_q <= 1'b0;
          if (blank_cnt == '0) begin
            state      <= LOAD;
            load_req_q <= 1'b1;
          end else begin
            blank_cnt <= blank_cnt - BCW'(1);
          end
        end
        LOAD: begin
          if (bus.load_ack) begin
            state      <= LATCH;
            load_req_q <= 1'b0;
            latch_q    <= 1'b1;
          end
        end
        LATCH: begin
          state    <= SHOW;
          latch_q  <= 1'b0;
          oe_q     <= 1'b1;
          show_cnt <= show_load;
        end
        SHOW: begin
          // The slot always runs to completion; enable only matters once it ends.
          if (show_cnt == '0) begin
            oe_q <= 1'b0;
            if (bus.enable) begin
              state         <= BLANK;
              layer_q       <= next_layer;
              bit_q         <= next_bit;
              frame_start_q <= next_frame;
              blank_cnt     <= BCW'(BLANK_CYCLES - 1);
            end else begin
              state   <= IDLE;
              layer_q <= '0;
              bit_q   <= '0;
            end
          end else begin
            show_cnt <= show_cnt - CW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          load_req_q <= 1'b0;
          latch_q    <= 1'b0;
          oe_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.layer       = layer_q;
  assign bus.bit_plane   = bit_q;
  assign bus.load_req    = load_req_q;
  assign bus.latch       = latch_q;
  assign bus.oe          = oe_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Directed bench for cube_scan_sequencer: a 2x2 cube for sequencing, stall, enable and reset,
// and a 3x3 cube for non-power-of-two index wrap.
module tb_cube_scan_sequencer;
  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  cube_scan_sequencer_if #(.LW(1), .BW(1)) bus_a ();
  cube_scan_sequencer_if #(.LW(2), .BW(2)) bus_b ();

  cube_scan_sequencer #(
    .LAYERS(2), .BITS(2), .TICK_SHIFT(0), .BLANK_CYCLES(2)
  ) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bus  (bus_a)
  );

  cube_scan_sequencer #(
    .LAYERS(3), .BITS(3), .TICK_SHIFT(0), .BLANK_CYCLES(2)
  ) dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ack, input logic rst);
    bus_a.enable   = en;
    bus_a.load_ack = ack;
    reset_a        = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Packed view of dut_a: {frame_start, oe, load_req, latch, layer, bit_plane}
  function automatic logic [31:0] snapA();
    return {26'd0, bus_a.frame_start, bus_a.oe, bus_a.load_req, bus_a.latch,
            bus_a.layer, bus_a.bit_plane};
  endfunction

  function automatic logic [31:0] vecA(input logic fs, input logic oe, input logic req,
                                       input logic lat, input logic ly, input logic bp);
    return {26'd0, fs, oe, req, lat, ly, bp};
  endfunction

  task automatic waitShow(input int l, input int b, input string tag);
    int n;
    n = 0;
    while (!(bus_a.oe === 1'b1 && int'(bus_a.layer) == l && int'(bus_a.bit_plane) == b) && n < 200) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(n < 200), 32'd1);
  endtask

  int s, p, bitv, slot_len, fs_first, fs_second, oe_total;
  int k, cyc, max_layer, max_bit;

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1);
    reset_b        = 1'b1;
    bus_b.enable   = 1'b1;
    bus_b.load_ack = 1'b1;

    repeat (3) tick();
    checkOutput("reset_hold", snapA(), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("reset_release", snapA(), vecA(1, 0, 0, 0, 0, 0));

    // Nominal: two frames of slots (0,0)5 (0,1)6 (1,0)5 (1,1)6 cycles
    s = 0; p = 0; fs_first = -1; fs_second = -1; oe_total = 0;
    for (int c = 0; c < 44; c++) begin
      bitv     = s % 2;
      slot_len = 4 + (1 << bitv);
      checkOutput("nominal", snapA(),
                  vecA(p == 0 && s == 0, p >= 4, p == 2, p == 3, 1'(s / 2), 1'(bitv)));
      if (bus_a.frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      if (bus_a.oe === 1'b1) oe_total++;
      p++;
      if (p == slot_len) begin
        p = 0;
        s = (s + 1) % 4;
      end
      tick();
    end
    checkOutput("frame_period", 32'(fs_second - fs_first), 32'd22);
    checkOutput("oe_total", 32'(oe_total), 32'd12);

    // Ack stall: ack withheld for 7 load_req cycles
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checkOutput("stall_req", {29'd0, bus_a.load_req, bus_a.oe, bus_a.latch}, 32'b100);
      if (i == 7) applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("stall_latch", {29'd0, bus_a.load_req, bus_a.oe, bus_a.latch}, 32'b001);
    tick();
    checkOutput("stall_show", {29'd0, bus_a.load_req, bus_a.oe, bus_a.latch}, 32'b010);

    // Enable drop in the first SHOW cycle of (1,1)
    waitShow(1, 1, "wait_show_11");
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("drop_show_tail", snapA(), vecA(0, 1, 0, 0, 1, 1));
    tick();
    checkOutput("drop_idle", snapA(), 32'd0);
    tick();
    checkOutput("drop_idle_hold", snapA(), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("reenable", snapA(), vecA(1, 0, 0, 0, 0, 0));

    // Reset in the middle of LOAD, then a late ack that must be ignored
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("mload_req", 32'(bus_a.load_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("mload_reset", snapA(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("late_ack", snapA(), 32'd0);
    tick();
    checkOutput("late_ack_hold", snapA(), 32'd0);

    // Reset in the middle of SHOW
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("restart", snapA(), vecA(1, 0, 0, 0, 0, 0));
    waitShow(0, 1, "wait_show_01");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("mshow_reset", snapA(), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("mshow_restart", snapA(), vecA(1, 0, 0, 0, 0, 0));

    // 3x3 cube: latch sees (layer,bit) in order, wrapping explicitly at 3
    reset_b = 1'b0;
    k = 0; cyc = 0; max_layer = 0; max_bit = 0;
    while (k < 10 && cyc < 300) begin
      if (int'(bus_b.layer) > max_layer) max_layer = int'(bus_b.layer);
      if (int'(bus_b.bit_plane) > max_bit) max_bit = int'(bus_b.bit_plane);
      if (bus_b.latch === 1'b1) begin
        checkOutput("wrap_idx", {28'd0, bus_b.layer, bus_b.bit_plane},
                    {28'd0, 2'((k / 3) % 3), 2'(k % 3)});
        k++;
      end
      tick();
      cyc++;
    end
    checkOutput("wrap_count", 32'(k), 32'd10);
    checkOutput("wrap_max_layer", 32'(max_layer), 32'd2);
    checkOutput("wrap_max_bit", 32'(max_bit), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
